// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-counter binary-to-BCD converter:
// FSM encoding, default sizes and the saturation constants.
package freq_pkg;

    localparam int BIN_W_DEF  = 27;
    localparam int DIGITS_DEF = 8;

    // Every digit reads 9 when the count does not fit on the display
    localparam logic [3:0] SAT_DIGIT = 4'h9;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } conv_state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1)
    function automatic logic [63:0] dec_limit(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/freq_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that
// feeds the display driver; the result only changes on the Done pulse.
module freq_bcd_conv
    import freq_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [BIN_W-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Ovf,
    output logic [4*DIGITS-1:0]   Bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CMP_W = 64;
    localparam logic [CMP_W-1:0] LIMIT = dec_limit(DIGITS);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    conv_state_t        state_r;
    conv_state_t        state_s;
    logic [BIN_W-1:0]   bin_sh_r;
    logic [BCD_W-1:0]   work_r;
    logic [BCD_W-1:0]   adj_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_pend_r;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   bcd_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work_r[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; Start is only looked at in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_SHIFT) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Working registers: load on acceptance, then correct-and-shift each SHIFT cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bin_sh_r   <= '0;
            work_r     <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        bin_sh_r   <= Bin;
                        work_r     <= '0;
                        cnt_r      <= '0;
                        ovf_pend_r <= ({{(CMP_W-BIN_W){1'b0}}, Bin} > LIMIT);
                    end else begin
                        bin_sh_r   <= bin_sh_r;
                        work_r     <= work_r;
                        cnt_r      <= cnt_r;
                        ovf_pend_r <= ovf_pend_r;
                    end
                end
                SHIFT: begin
                    work_r   <= {adj_s[BCD_W-2:0], bin_sh_r[BIN_W-1]};
                    bin_sh_r <= {bin_sh_r[BIN_W-2:0], 1'b0};
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                default: begin
                    bin_sh_r   <= bin_sh_r;
                    work_r     <= work_r;
                    cnt_r      <= cnt_r;
                    ovf_pend_r <= ovf_pend_r;
                end
            endcase
        end
    end

    // Registered outputs trail the FSM by one clock so Done and the new Bcd coincide
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            bcd_r  <= '0;
        end else begin
            busy_r <= (state_r != IDLE);
            done_r <= (state_r == DONE);
            if (state_r == DONE) begin
                ovf_r <= ovf_pend_r;
                bcd_r <= ovf_pend_r ? {DIGITS{SAT_DIGIT}} : work_r;
            end else begin
                ovf_r <= ovf_r;
                bcd_r <= bcd_r;
            end
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign Ovf  = ovf_r;
    assign Bcd  = bcd_r;

endmodule
